// File: rtl/tdes_key_scheduler.sv
// Purpose : 3DES (EDE / DED) round-subkey generator, one 48-bit subkey per valid/ready handshake.
// Latency : first subkey 2 cycles after enable is sampled; 48 subkeys + 3 LOAD bubbles, done 51 cycles after enable.
// Backpr. : subkey held stable while subkeyValid && !subkeyReady, stalls unbounded.
//
// Ports:
//   HCLK, HRESET            clock (rising edge), async active-low reset
//   enable, encryptionType  start request (sampled in IDLE only), 1 = encrypt (E-D-E)
//   key1, key2, key3        64-bit DES keys (parity bits at 8,16,..,64 in FIPS numbering)
//   subkeyReady             round datapath accepts current subkey
//   subkey, subkeyValid     current round subkey and its valid
//   roundNum, passNum       round 0..15 within pass, pass 0..2
//   passDecrypt, lastRound  current pass direction, final subkey marker
//   busy, done, keyError    run in progress, end-of-run pulse, parity failure pulse
// Optional feature macro: TDES_KEY_PARITY_CHECK_EN (odd-parity key check at acceptance).
module tdes_key_scheduler #(
  parameter int KEYING_OPTION = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic        encryptionType,
  input  logic [63:0] key1,
  input  logic [63:0] key2,
  input  logic [63:0] key3,
  input  logic        subkeyReady,
  output logic [47:0] subkey,
  output logic        subkeyValid,
  output logic [3:0]  roundNum,
  output logic [1:0]  passNum,
  output logic        passDecrypt,
  output logic        lastRound,
  output logic        busy,
  output logic        done,
  output logic        keyError
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  // FIPS 46-3 tables, bit 1 = MSB of the source vector.
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] o;
    cd = {c, d};
    o  = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
    return o;
  endfunction

  // Encrypt shift of round idx is 1 for rounds 0,1,8,15 and 2 otherwise.
  function automatic logic shift_is_two(input logic [3:0] idx);
    return !((idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15));
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state;
  logic [63:0] k1_q, k2_q, k3_q;
  logic        enc_q;
  logic [27:0] c_q, d_q;
  logic [63:0] pass_key;
  logic        pass_dec;
  logic [55:0] pc1_key;
  logic        keys_ok;

  // Encrypt: K1 enc, K2 dec, K3 enc.  Decrypt: K3 dec, K2 enc, K1 dec.
  always_comb begin
    pass_key = k2_q;
    if (passNum == 2'd0)      pass_key = enc_q ? k1_q : k3_q;
    else if (passNum == 2'd2) pass_key = enc_q ? k3_q : k1_q;
  end

  assign pass_dec = enc_q ? (passNum == 2'd1) : (passNum != 2'd1);
  assign pc1_key  = pc1(pass_key);

`ifdef TDES_KEY_PARITY_CHECK_EN
  function automatic logic odd_parity_ok(input logic [63:0] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok = ok & (^k[8*b +: 8]);
    return ok;
  endfunction

  logic key_err_q;

  // key3 is not used in two-key mode, so its parity is irrelevant there.
  assign keys_ok = odd_parity_ok(key1) & odd_parity_ok(key2) &
                   ((KEYING_OPTION == 2) | odd_parity_ok(key3));

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) key_err_q <= 1'b0;
    else         key_err_q <= (state == IDLE) && enable && !keys_ok;
  end

  assign keyError = key_err_q;
`else
  assign keys_ok  = 1'b1;
  assign keyError = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state    <= IDLE;
      k1_q     <= '0;
      k2_q     <= '0;
      k3_q     <= '0;
      enc_q    <= 1'b0;
      c_q      <= '0;
      d_q      <= '0;
      roundNum <= '0;
      passNum  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && keys_ok) begin
            k1_q     <= key1;
            k2_q     <= key2;
            k3_q     <= (KEYING_OPTION == 2) ? key1 : key3;
            enc_q    <= encryptionType;
            busy     <= 1'b1;
            passNum  <= '0;
            roundNum <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          // Decrypt starts from C16 == C0, so no rotation on load.
          c_q      <= pass_dec ? pc1_key[55:28] : rotl(pc1_key[55:28], 1'b0);
          d_q      <= pass_dec ? pc1_key[27:0]  : rotl(pc1_key[27:0],  1'b0);
          roundNum <= '0;
          state    <= ROUND;
        end
        ROUND: begin
          if (subkeyReady) begin
            if (roundNum == 4'd15) begin
              roundNum <= '0;
              if (passNum == 2'd2) begin
                passNum <= '0;
                done    <= 1'b1;
                state   <= DONE;
              end else begin
                passNum <= passNum + 2'd1;
                state   <= LOAD;
              end
            end else begin
              roundNum <= roundNum + 4'd1;
              // Decrypt walks the encrypt schedule backwards: undo shift of round 15-r.
              if (pass_dec) begin
                c_q <= rotr(c_q, shift_is_two(4'd15 - roundNum));
                d_q <= rotr(d_q, shift_is_two(4'd15 - roundNum));
              end else begin
                c_q <= rotl(c_q, shift_is_two(roundNum + 4'd1));
                d_q <= rotl(d_q, shift_is_two(roundNum + 4'd1));
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign subkeyValid = (state == ROUND);
  assign subkey      = subkeyValid ? pc2(c_q, d_q) : '0;
  assign passDecrypt = ((state == LOAD) || (state == ROUND)) && pass_dec;
  assign lastRound   = subkeyValid && (passNum == 2'd2) && (roundNum == 4'd15);

endmodule

// File: tb/tb_tdes_key_scheduler.sv
module tb_tdes_key_scheduler;

  localparam logic [63:0] KA    = 64'h133457799BBCDFF1;
  localparam logic [63:0] KB    = 64'h0123456789ABCDEF;
  localparam logic [63:0] KC    = 64'hFEDCBA9876543210;
  localparam logic [63:0] KABAD = 64'h133457799BBCDF12;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        enable = 1'b0;
  logic        encryptionType = 1'b0;
  logic [63:0] key1 = '0, key2 = '0, key3 = '0;
  logic        subkeyReady = 1'b1;

  logic [47:0] subkey, subkey_b;
  logic        subkeyValid, subkeyValid_b;
  logic [3:0]  roundNum, roundNum_b;
  logic [1:0]  passNum, passNum_b;
  logic        passDecrypt, passDecrypt_b, lastRound, lastRound_b;
  logic        busy, busy_b, done, done_b, keyError, keyError_b;

  tdes_key_scheduler #(.KEYING_OPTION(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .encryptionType(encryptionType),
    .key1(key1), .key2(key2), .key3(key3), .subkeyReady(subkeyReady),
    .subkey(subkey), .subkeyValid(subkeyValid), .roundNum(roundNum), .passNum(passNum),
    .passDecrypt(passDecrypt), .lastRound(lastRound), .busy(busy), .done(done),
    .keyError(keyError)
  );

  tdes_key_scheduler #(.KEYING_OPTION(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable), .encryptionType(encryptionType),
    .key1(key1), .key2(key2), .key3(key3), .subkeyReady(subkeyReady),
    .subkey(subkey_b), .subkeyValid(subkeyValid_b), .roundNum(roundNum_b), .passNum(passNum_b),
    .passDecrypt(passDecrypt_b), .lastRound(lastRound_b), .busy(busy_b), .done(done_b),
    .keyError(keyError_b)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rn;
    logic [1:0]  pn;
    logic        pd;
    logic        lr;
  } exp_t;

  exp_t        q[$];
  logic [47:0] ks [16];
  logic [47:0] d2 [4][16];
  logic [47:0] cap_r0, cap_r15;
  logic        cap_pd [4];
  int          hs_cnt, bubbles;
  bit          seen_v, stalled, rec2, rdy_random;
  logic [47:0] hold_sk;
  logic [3:0]  hold_rn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference schedule: each round's C/D derived from C0/D0 by the cumulative shift.
  task automatic gen_ks(input logic [63:0] key);
    logic [55:0] cd0, cdr;
    logic [27:0] c, d;
    logic [47:0] k;
    int cum;
    cd0 = '0;
    for (int i = 0; i < 56; i++) cd0[6'(55 - i)] = key[6'(64 - PC1[i])];
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum += (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
      c = cd0[55:28];
      d = cd0[27:0];
      for (int s = 0; s < cum; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cdr = {c, d};
      k = '0;
      for (int j = 0; j < 48; j++) k[6'(47 - j)] = cdr[6'(56 - PC2[j])];
      ks[r] = k;
    end
  endtask

  task automatic push_run(input logic [63:0] k1, input logic [63:0] k2,
                          input logic [63:0] k3, input logic enc);
    exp_t e;
    logic dec;
    logic [63:0] pk;
    for (int p = 0; p < 3; p++) begin
      dec = enc ? (p == 1) : (p != 1);
      pk  = (p == 1) ? k2 : (((p == 0) == enc) ? k1 : k3);
      gen_ks(pk);
      for (int r = 0; r < 16; r++) begin
        e.sk = dec ? ks[15 - r] : ks[r];
        e.rn = 4'(r);
        e.pn = 2'(p);
        e.pd = dec;
        e.lr = (p == 2 && r == 15);
        q.push_back(e);
      end
    end
  endtask

  task automatic pulse_enable(input logic [63:0] k1, input logic [63:0] k2,
                              input logic [63:0] k3, input logic enc);
    @(posedge HCLK); #1;
    key1 = k1; key2 = k2; key3 = k3; encryptionType = enc; enable = 1'b1;
    @(posedge HCLK); #1;
    enable = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_subkey"}, subkey, 0);
    chk({tag, "_valid"}, subkeyValid, 0);
    chk({tag, "_round"}, roundNum, 0);
    chk({tag, "_pass"}, passNum, 0);
    chk({tag, "_pdec"}, passDecrypt, 0);
    chk({tag, "_last"}, lastRound, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_keyerr"}, keyError, 0);
  endtask

  // Full run: optional scramble changes keys/type after acceptance and re-pokes enable mid-run.
  task automatic run(input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3,
                     input logic enc, input bit scramble, output int done_at, output int first_v);
    push_run(k1, k2, k3, enc);
    hs_cnt = 0; bubbles = 0; seen_v = 0;
    pulse_enable(k1, k2, k3, enc);
    if (scramble) begin
      key1 = ~k1; key2 = ~k2; key3 = ~k3; encryptionType = ~enc;
    end
    done_at = -1;
    first_v = -1;
    for (int n = 1; n <= 3000 && done_at < 0; n++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      if (scramble && n == 10) enable = 1'b1;
      else if (n == 11) enable = 1'b0;
      if (n == 1) chk("busy_running", busy, 1);
      if (subkeyValid && first_v < 0) first_v = n;
      if (done) done_at = n;
    end
    enable = 1'b0;
    chk("done_seen", done_at > 0, 1);
    chk("handshakes", hs_cnt, 48);
    chk("bubbles", bubbles, 2);
    chk("sb_empty", q.size(), 0);
    @(negedge HCLK);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", subkeyValid, 0);
  endtask

  initial begin : ready_drv
    int stall;
    stall = 0;
    forever begin
      @(posedge HCLK); #1;
      if (rdy_random) begin
        if (stall >= 20 || $urandom_range(0, 99) < 30) begin
          subkeyReady = 1'b1;
          stall = 0;
        end else begin
          subkeyReady = 1'b0;
          stall++;
        end
      end else begin
        subkeyReady = 1'b1;
        stall = 0;
      end
    end
  end

  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESET) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_valid", subkeyValid, 1);
        chk("stall_subkey", subkey, hold_sk);
        chk("stall_round", roundNum, hold_rn);
      end
      if (!subkeyValid) chk("lastround_gated", lastRound, 0);
`ifndef TDES_KEY_PARITY_CHECK_EN
      chk("keyerror_tied", keyError, 0);
`endif
      if (subkeyValid && subkeyReady) begin
        if (q.size() > 0) e = q.pop_front();
        else e = 'x;
        chk("sb_subkey", subkey, e.sk);
        chk("sb_round", roundNum, e.rn);
        chk("sb_pass", passNum, e.pn);
        chk("sb_pdec", passDecrypt, e.pd);
        chk("sb_last", lastRound, e.lr);
        hs_cnt++;
        if (passNum == 2'd0 && roundNum == 4'd0)  cap_r0  = subkey;
        if (passNum == 2'd0 && roundNum == 4'd15) cap_r15 = subkey;
        cap_pd[passNum] = passDecrypt;
      end
      if (seen_v && busy && !subkeyValid && !done) bubbles++;
      if (subkeyValid) seen_v = 1;
      stalled = subkeyValid && !subkeyReady;
      hold_sk = subkey;
      hold_rn = roundNum;
      if (rec2 && subkeyValid_b && subkeyReady) d2[passNum_b][roundNum_b] = subkey_b;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int done_at, first_v, found;
    rec2 = 0;
    rdy_random = 0;

    // Reset state
    repeat (2) @(negedge HCLK);
    check_zero("reset");
    @(posedge HCLK); #2;
    HRESET = 1'b1;

    // Encrypt known-answer run; keys/type scrambled and enable re-poked after acceptance
    run(KA, KA, KA, 1'b1, 1'b1, done_at, first_v);
    chk("enc_first_valid", first_v, 1);
    chk("enc_done_latency", done_at, 51);
    chk("enc_kat_r0", cap_r0, 48'h1B02EFFC7072);
    chk("enc_kat_r15", cap_r15, 48'hCB3D8B0E17F5);

    // Decrypt known-answer run
    run(KA, KA, KA, 1'b0, 1'b0, done_at, first_v);
    chk("dec_done_latency", done_at, 51);
    chk("dec_kat_r0", cap_r0, 48'hCB3D8B0E17F5);
    chk("dec_kat_r15", cap_r15, 48'h1B02EFFC7072);
    chk("dec_pdec_p0", cap_pd[0], 1);
    chk("dec_pdec_p1", cap_pd[1], 0);
    chk("dec_pdec_p2", cap_pd[2], 1);

    // Distinct keys: three-key instance via scoreboard, two-key instance recorded
    rec2 = 1;
    run(KA, KB, KC, 1'b1, 1'b0, done_at, first_v);
    rec2 = 0;
    gen_ks(KA);
    for (int r = 0; r < 16; r++) begin
      chk("opt2_pass0", d2[0][r], ks[r]);
      chk("opt2_pass2", d2[2][r], ks[r]);
    end

    // Random backpressure, decrypt with distinct keys
    rdy_random = 1;
    run(KC, KB, KA, 1'b0, 1'b0, done_at, first_v);
    rdy_random = 0;

    // Reset mid-operation at pass1 round7, then a clean run
    push_run(KA, KB, KC, 1'b1);
    hs_cnt = 0; seen_v = 0;
    pulse_enable(KA, KB, KC, 1'b1);
    found = 0;
    for (int n = 0; n < 400 && found == 0; n++) begin
      @(negedge HCLK);
      if (subkeyValid && passNum == 2'd1 && roundNum == 4'd7) found = 1;
    end
    chk("reached_p1r7", found, 1);
    #1 HRESET = 1'b0;
    #1 check_zero("abort");
    q.delete();
    @(posedge HCLK); #1;
    check_zero("abort_edge");
    @(posedge HCLK); #2;
    HRESET = 1'b1;
    run(KA, KB, KC, 1'b1, 1'b0, done_at, first_v);
    chk("post_reset_latency", done_at, 51);

    // Even-parity byte in key2
`ifdef TDES_KEY_PARITY_CHECK_EN
    hs_cnt = 0;
    pulse_enable(KA, KABAD, KC, 1'b1);
    @(negedge HCLK);
    chk("par_keyerror", keyError, 1);
    chk("par_busy", busy, 0);
    chk("par_valid", subkeyValid, 0);
    for (int n = 0; n < 4; n++) begin
      @(negedge HCLK);
      chk("par_keyerror_pulse", keyError, 0);
      chk("par_busy_idle", busy, 0);
      chk("par_no_valid", subkeyValid, 0);
    end
    chk("par_no_handshakes", hs_cnt, 0);
`else
    run(KA, KABAD, KC, 1'b1, 1'b0, done_at, first_v);
    chk("nopar_latency", done_at, 51);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdes_key_scheduler.md
Name: tdes_key_scheduler

Overview:
- Sits directly downstream of the AHB slave interface. Consumes its enable, encryptionType and key1/key2/key3 outputs.
- Streams one 48-bit DES round subkey per handshake to the round datapath.
- Covers all 48 rounds of a 3DES EDE operation: 3 passes x 16 rounds, with the correct key order and shift direction for each pass.
- Subkeys follow FIPS 46-3 (PC-1, per-round rotations, PC-2).

Parameters:
- KEYING_OPTION, 1, 1 = three independent keys; 2 = two-key 3DES, where key1 is used in place of key3.

Ports:
- HCLK  input  1  system clock, rising edge
- HRESET  input  1  asynchronous, active-low reset
- enable  input  1  start request; sampled only in IDLE
- encryptionType  input  1  1 = encrypt (E-D-E), 0 = decrypt (D-E-D)
- key1  input  64  DES key 1, parity bits in positions 8,16,...,64
- key2  input  64  DES key 2
- key3  input  64  DES key 3
- subkeyReady  input  1  round datapath accepts the current subkey
- subkey  output  48  current round subkey
- subkeyValid  output  1  subkey is valid
- roundNum  output  4  round index 0..15 within the pass
- passNum  output  2  pass index 0..2
- passDecrypt  output  1  current pass runs the DES decrypt direction
- lastRound  output  1  high with the final subkey (pass 2, round 15)
- busy  output  1  high from enable acceptance until done
- done  output  1  one-cycle pulse after the last subkey is accepted
- keyError  output  1  parity failure pulse (optional feature only)

Behaviour:
- Reset (async, HRESET=0): state IDLE. All outputs 0. Latched keys, C/D registers and counters cleared. Reset mid-operation aborts immediately, with no further subkeys.
- States: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - enable=1 latches key1..3 and encryptionType, sets busy=1, and moves to LOAD.
  - With KEYING_OPTION=2, the latched key3 is taken from key1.
- Pass order and direction:
  - Encrypt: pass0 = K1 encrypt, pass1 = K2 decrypt, pass2 = K3 encrypt.
  - Decrypt: pass0 = K3 decrypt, pass1 = K2 encrypt, pass2 = K1 decrypt.
  - passDecrypt reflects the direction of the current pass.
- LOAD (1 cycle): C/D (28 bits each) are loaded from PC-1 of the pass key.
  - Encrypt direction: the left-rotate-by-1 for round 0 is applied in the same cycle.
  - Decrypt direction: no rotation, since C16=C0.
  - Next state is ROUND with roundNum=0.
- ROUND:
  - subkeyValid=1 and subkey=PC-2(C,D), combinational from registers.
  - Subkey must be stable while subkeyValid=1 and subkeyReady=0; stalls are unbounded.
  - On subkeyValid&&subkeyReady, roundNum increments and C/D rotate for the next round.
  - Shift schedule for encrypt round r=1..15: left by the r-th entry of 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt direction, step from round r to r+1: rotate right by the encrypt shift of round 15-r. Decrypt subkey r therefore always equals encrypt subkey 15-r.
- Pass boundaries:
  - Handshake at roundNum=15 with passNum<2: passNum increments and the block goes to LOAD. This gives one bubble cycle with subkeyValid=0.
  - Handshake at passNum=2, roundNum=15 goes to DONE.
- Latency:
  - First subkey valid 2 cycles after the cycle enable is sampled.
  - Full run with subkeyReady tied high: 48 subkeys in 50 cycles after enable. done is asserted in cycle 51.
- DONE (1 cycle): done=1, subkeyValid=0, busy=0 in the following IDLE cycle.
- enable while busy is ignored. Key or encryptionType changes after acceptance have no effect.
- lastRound is asserted only together with subkeyValid.

Optional Feature:
- Macro: TDES_KEY_PARITY_CHECK_EN.
- When defined:
  - At acceptance in IDLE, each byte of every used key is checked for odd parity.
  - Any failure pulses keyError=1 for one cycle, stays in IDLE, asserts busy=0, and generates no subkeys.
- When undefined: parity bits are ignored and keyError is tied to 0.

Test Plan:
- key1=key2=key3=133457799BBCDFF1, encryptionType=1, subkeyReady=1 -> pass0 round0 subkey=1B02EFFC7072, round15=CB3D8B0E17F5; done asserted 51 cycles after enable.
- Same keys, encryptionType=0 -> pass0 round0=CB3D8B0E17F5, round15=1B02EFFC7072; passDecrypt sequence 1,0,1.
- Distinct keys K1/K2/K3, KEYING_OPTION=2 -> pass2 subkeys identical to pass0 subkeys.
- subkeyReady random 30% duty, stalls up to 20 cycles -> subkey/roundNum stable during each stall; exactly 48 handshakes; one bubble at each pass boundary.
- HRESET low at pass1 round7 -> all outputs 0 next edge; new enable yields a clean run from pass0 round0.
- With TDES_KEY_PARITY_CHECK_EN, key2 byte0 = 0x12 (even parity) -> keyError pulse, busy stays 0, no subkeyValid.
